// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the set/reset latch command arbiter.
package sr_ctrl_pkg;

    // Command sequencer states: wait for a request, drive the latch, settle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Encoding of the per-requester op bit.
    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after last_grant,
// wrapping modulo NREQ.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            valid,
    output logic [IW-1:0]   index
);

    int cand;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = (int'(last_grant) + off) % NREQ;
            if (req[cand]) begin
                valid = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Arbitrates set/reset commands from NREQ requesters onto one SR latch.
// Each granted command drives s_out or r_out for PULSE_CYC cycles, then
// spends one quiet GAP cycle in which the requester is acknowledged.
module sr_cmd_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int PULSE_CYC = 2,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    input  logic            q_in,
    output logic            s_out,
    output logic            r_out,
    output logic [NREQ-1:0] ack,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(PULSE_CYC + 1);

    state_t          state;
    logic            op_q;
    logic [IW-1:0]   last_grant;
    logic [CW-1:0]   cnt;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req       (req),
        .last_grant(last_grant),
        .valid     (pick_valid),
        .index     (pick_idx)
    );

    assign busy = (state != IDLE);

    // Sequencer with registered latch drives, ack pulse and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state elements are updated with non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            s_out      <= 1'b0;
            r_out      <= 1'b0;
            ack        <= '0;
            grant_id   <= '0;
            last_grant <= IW'(NREQ - 1);
            op_q       <= OP_RST;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack   <= '0;
                    s_out <= 1'b0;
                    r_out <= 1'b0;
                    cnt   <= CW'(PULSE_CYC);
                    if (pick_valid) begin
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        op_q       <= op[pick_idx];
                        // s and r come from one op bit, so they can never both rise.
                        s_out      <= (op[pick_idx] == OP_SET);
                        r_out      <= (op[pick_idx] == OP_RST);
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CW'(1)) begin
                        state <= GAP;
                        s_out <= 1'b0;
                        r_out <= 1'b0;
                        ack   <= NREQ'(1) << grant_id;
                        // Latch has settled after the full pulse; compare here so
                        // err is already visible during the GAP cycle.
                        if (q_in != op_q) begin
                            err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    s_out <= 1'b0;
                    r_out <= 1'b0;
                    ack   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Scoreboard bench for sr_cmd_arbiter: directed commands push the expected
// (requester, op) pair; the monitor pops and compares on every ack.
module tb_sr_cmd_arbiter;

    localparam int NREQ      = 4;
    localparam int PULSE_CYC = 2;
    localparam int LAT       = PULSE_CYC + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] op  = '0;
    logic            q_in = 1'b0;
    logic            s_out;
    logic            r_out;
    logic [NREQ-1:0] ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err;

    typedef struct {
        int   id;
        logic op;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   ack_cyc_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   viol    = 0;
    int   pulse_len = 0;
    logic pulse_op  = 1'b0;
    logic prev_act  = 1'b0;
    logic latch_en  = 1'b1;

    always #5 clk = ~clk;

    sr_cmd_arbiter #(
        .NREQ     (NREQ),
        .PULSE_CYC(PULSE_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op      (op),
        .q_in    (q_in),
        .s_out   (s_out),
        .r_out   (r_out),
        .ack     (ack),
        .grant_id(grant_id),
        .busy    (busy),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: exclusivity/onehot every cycle, pulse tracking, scoreboard pop, latch model.
    always @(negedge clk) begin
        cyc++;
        if ((s_out && r_out) || !$onehot0(ack)) viol++;
        if (s_out || r_out) begin
            if (!prev_act) begin
                pulse_len = 1;
                pulse_op  = s_out;
            end else begin
                pulse_len++;
            end
        end
        prev_act = s_out || r_out;
        if (ack != '0) begin
            ack_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("ack_unexpected", 32'(ack), 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_vec",   32'(ack), 32'(1) << mon_e.id);
                check("grant_id",  32'(grant_id), mon_e.id);
                check("pulse_len", pulse_len, PULSE_CYC);
                check("pulse_op",  32'(pulse_op), 32'(mon_e.op));
            end
        end
        if (latch_en) begin
            if (s_out)      q_in = 1'b1;
            else if (r_out) q_in = 1'b0;
        end
    end

    task automatic wait_ack(input int budget, output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (ack != '0) ok = 1'b1;
        end
    endtask

    // Present a request for one sampling edge, then drop it and flip op.
    task automatic issue(input logic [NREQ-1:0] r, input logic [NREQ-1:0] o);
        @(posedge clk); #1;
        req = r;
        op  = o;
        @(posedge clk); #1;
        req = '0;
        op  = ~o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   n;
        logic ok;
        int   rr_acks;
        int   stray;

        // Reset values, asynchronous (no clock edge has occurred yet).
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_s_out",    32'(s_out), 0);
        check("rst_r_out",    32'(r_out), 0);
        check("rst_ack",      32'(ack), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_err",      32'(err), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single set command from requester 0.
        sb_q.push_back('{id: 0, op: 1'b1});
        issue(4'b0001, 4'b0001);
        wait_ack(20, n, ok);
        check("single_ack_seen", 32'(ok), 1);
        check("single_latency",  n, LAT);
        check("single_err",      32'(err), 0);
        @(posedge clk); #1;
        check("single_idle_busy", 32'(busy), 0);

        // Round-robin with all requests held from reset.
        do_reset();
        ack_cyc_q.delete();
        sb_q.push_back('{id: 0, op: 1'b0});
        sb_q.push_back('{id: 1, op: 1'b1});
        sb_q.push_back('{id: 2, op: 1'b1});
        sb_q.push_back('{id: 3, op: 1'b0});
        sb_q.push_back('{id: 0, op: 1'b0});
        @(posedge clk); #1;
        req = 4'b1111;
        op  = 4'b0110;
        rr_acks = 0;
        for (int i = 0; i < 60 && rr_acks < 5; i++) begin
            @(negedge clk);
            if (ack != '0) rr_acks++;
        end
        @(posedge clk); #1;
        req = '0;
        check("rr_ack_count", rr_acks, 5);
        check("rr_ack_log",   ack_cyc_q.size(), 5);
        for (int i = 1; i < ack_cyc_q.size(); i++) begin
            check("rr_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], PULSE_CYC + 2);
        end
        check("rr_err", 32'(err), 0);

        // Early drop: one-cycle reset request from requester 2.
        sb_q.push_back('{id: 2, op: 1'b0});
        issue(4'b0100, 4'b0000);
        wait_ack(20, n, ok);
        check("drop_ack_seen", 32'(ok), 1);
        check("drop_latency",  n, LAT);
        check("drop_err",      32'(err), 0);

        // Mismatch: latch stuck at 0 while a set is commanded.
        @(posedge clk); #1;
        latch_en = 1'b0;
        q_in     = 1'b0;
        check("mm_err_before", 32'(err), 0);
        sb_q.push_back('{id: 1, op: 1'b1});
        issue(4'b0010, 4'b0010);
        wait_ack(20, n, ok);
        check("mm_ack_seen", 32'(ok), 1);
        check("mm_err_gap",  32'(err), 1);
        latch_en = 1'b1;
        sb_q.push_back('{id: 3, op: 1'b0});
        issue(4'b1000, 4'b0000);
        wait_ack(20, n, ok);
        check("mm_good_ack_seen", 32'(ok), 1);
        check("mm_err_sticky",    32'(err), 1);
        do_reset();
        check("mm_err_cleared", 32'(err), 0);

        // Reset asserted in the first DRIVE cycle aborts the command.
        @(posedge clk); #1;
        req = 4'b0100;
        op  = 4'b0100;
        @(posedge clk); #1;
        req = '0;
        check("abort_busy_drive", 32'(busy), 1);
        check("abort_s_drive",    32'(s_out), 1);
        rst_n = 1'b0;
        #1;
        check("abort_s_async",    32'(s_out), 0);
        check("abort_r_async",    32'(r_out), 0);
        check("abort_busy_async", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack != '0 || busy) stray++;
        end
        check("abort_no_ack", stray, 0);
        sb_q.push_back('{id: 0, op: 1'b1});
        issue(4'b0101, 4'b0001);
        wait_ack(20, n, ok);
        check("abort_next_ack_seen", 32'(ok), 1);
        check("abort_next_latency",  n, LAT);

        repeat (3) @(negedge clk);
        check("sr_excl_onehot_viol", viol, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
